// File: rtl/mem_bus_arbiter_if.sv
// Request/acknowledge bus between one master and the memory arbiter.
// The master drives req/we/addr/wdata; the arbiter answers with ack/rdata.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input  ack, rdata);
  modport slave  (input  req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for a single-port memory: serialises requests into one-cycle
// read/write strobes, waits the fixed read latency and returns data to the owner.
module mem_bus_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1,
  parameter int PRIORITY_M1 = 0
) (
  input  logic                clk,
  input  logic                rst,
  mem_bus_arbiter_if.slave    m0,
  mem_bus_arbiter_if.slave    m1,
  output logic                mem_rd_en_o,
  output logic                mem_wr_en_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_data_o,
  input  logic [DATA_W-1:0]   mem_data_i,
  output logic                busy_o,
  output logic                owner_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              busy_q, busy_d;

  // Returns 1 when M1 should be granted this cycle.
  function automatic logic pick_m1(input logic r0, input logic r1, input logic last);
    if (r0 && r1)
      return (PRIORITY_M1 != 0) ? 1'b1 : !last;
    return r1;
  endfunction

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    case (state_q)
      IDLE: begin
        if (m0.req || m1.req) begin
          owner_d = pick_m1(m0.req, m1.req, last_owner_q);
          we_d    = owner_d ? m1.we    : m0.we;
          addr_d  = owner_d ? m1.addr  : m0.addr;
          wdata_d = owner_d ? m1.wdata : m0.wdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = RESP;
        end else begin
          cnt_d   = 4'(MEM_LATENCY);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // Count of 1 marks the last latency cycle: memory data is valid now.
        if (cnt_q == 4'd1) begin
          if (owner_q) rdata1_d = mem_data_i;
          else         rdata0_d = mem_data_i;
          state_d = RESP;
        end
      end
      RESP: begin
        last_owner_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    rd_en_d = (state_d == ISSUE) && !we_d;
    wr_en_d = (state_d == ISSUE) &&  we_d;
    ack0_d  = (state_d == RESP)  && !owner_d;
    ack1_d  = (state_d == RESP)  &&  owner_d;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      busy_q       <= busy_d;
    end
  end

  assign m0.ack      = ack0_q;
  assign m0.rdata    = rdata0_q;
  assign m1.ack      = ack1_q;
  assign m1.rdata    = rdata1_q;
  assign mem_rd_en_o = rd_en_q;
  assign mem_wr_en_o = wr_en_q;
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = wdata_q;
  assign busy_o      = busy_q;
  assign owner_o     = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: arbiter A (round-robin, latency 2) takes the single-transaction
// table and reset abort; arbiter B (M1 priority) shares the tie stimulus for comparison.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a0 ();
  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a1 ();
  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();

  assign a0.req = m0_req; assign a0.we = m0_we; assign a0.addr = m0_addr; assign a0.wdata = m0_wdata;
  assign a1.req = m1_req; assign a1.we = m1_we; assign a1.addr = m1_addr; assign a1.wdata = m1_wdata;
  assign b0.req = m0_req; assign b0.we = m0_we; assign b0.addr = m0_addr; assign b0.wdata = m0_wdata;
  assign b1.req = m1_req; assign b1.we = m1_we; assign b1.addr = m1_addr; assign b1.wdata = m1_wdata;

  logic        rd_a, wr_a, busy_a, owner_a, rd_b, wr_b, busy_b, owner_b;
  logic [31:0] addr_a, dout_a, din_a, addr_b, dout_b;
  logic [31:0] din_b = 32'h0;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2), .PRIORITY_M1(0)) dut_a (
    .clk(clk), .rst(rst), .m0(a0), .m1(a1),
    .mem_rd_en_o(rd_a), .mem_wr_en_o(wr_a), .mem_addr_o(addr_a), .mem_data_o(dout_a),
    .mem_data_i(din_a), .busy_o(busy_a), .owner_o(owner_a));

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .PRIORITY_M1(1)) dut_b (
    .clk(clk), .rst(rst), .m0(b0), .m1(b1),
    .mem_rd_en_o(rd_b), .mem_wr_en_o(wr_b), .mem_addr_o(addr_b), .mem_data_o(dout_b),
    .mem_data_i(din_b), .busy_o(busy_b), .owner_o(owner_b));

  // Memory model for A: data is driven only in the cycle two cycles after the strobe.
  function automatic logic [31:0] rdfun(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  logic [1:0]  pv;
  logic [31:0] pa0, pa1;
  always_ff @(posedge clk) begin
    if (rst) pv <= 2'b00;
    else     pv <= {pv[0], rd_a};
    pa0 <= addr_a;
    pa1 <= pa0;
  end
  assign din_a = pv[1] ? rdfun(pa1) : 32'hBAD0BAD0;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  typedef struct {
    bit          mst;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] r0;
    logic [31:0] r1;
    bit          drop;
  } vec_t;

  vec_t vecs[7];

  task automatic set_req(input bit mst, input logic v);
    if (mst) m1_req = v; else m0_req = v;
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    int ack_cyc = -1, n_ack = 0, n_rd = 0, n_wr = 0, strb_cyc = -1, bad_ack = 0, own_bad = 0;
    logic [31:0] s_addr = 0, s_data = 0, r_at_ack = 0;
    logic own_ack, oth_ack;
    string t;
    t = $sformatf("v%0d", idx);
    if (v.mst) begin m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata; end
    else       begin m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata; end
    set_req(v.mst, 1'b1);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin
        // Change the master inputs after the latch; the transaction must not see it.
        if (v.mst) begin m1_addr = ~v.addr; m1_wdata = ~v.wdata; m1_we = ~v.we; end
        else       begin m0_addr = ~v.addr; m0_wdata = ~v.wdata; m0_we = ~v.we; end
        if (v.drop) set_req(v.mst, 1'b0);
      end
      if (rd_a) begin n_rd++; strb_cyc = c; s_addr = addr_a; end
      if (wr_a) begin n_wr++; strb_cyc = c; s_addr = addr_a; s_data = dout_a; end
      if (busy_a && owner_a != v.mst) own_bad++;
      own_ack = v.mst ? a1.ack : a0.ack;
      oth_ack = v.mst ? a0.ack : a1.ack;
      if (oth_ack) bad_ack++;
      if (own_ack) begin
        n_ack++;
        if (ack_cyc < 0) begin
          ack_cyc  = c;
          r_at_ack = v.mst ? a1.rdata : a0.rdata;
        end
        set_req(v.mst, 1'b0);
      end
    end
    chk({t, "_ack_latency"}, ack_cyc, v.lat);
    chk({t, "_ack_count"}, n_ack, 1);
    chk({t, "_rd_strobes"}, n_rd, v.we ? 0 : 1);
    chk({t, "_wr_strobes"}, n_wr, v.we ? 1 : 0);
    chk({t, "_strobe_cycle"}, strb_cyc, 1);
    chk({t, "_mem_addr"}, s_addr, v.addr);
    if (v.we) chk({t, "_mem_wdata"}, s_data, v.wdata);
    chk({t, "_other_ack"}, bad_ack, 0);
    chk({t, "_owner"}, own_bad, 0);
    chk({t, "_rdata_at_ack"}, r_at_ack, v.mst ? v.r1 : v.r0);
    chk({t, "_m0_rdata"}, a0.rdata, v.r0);
    chk({t, "_m1_rdata"}, a1.rdata, v.r1);
    chk({t, "_idle_after"}, busy_a, 0);
  endtask

  task automatic check_reset_outputs(input string t);
    chk({t, "_busy"}, busy_a, 0);
    chk({t, "_owner"}, owner_a, 0);
    chk({t, "_rd_en"}, rd_a, 0);
    chk({t, "_wr_en"}, wr_a, 0);
    chk({t, "_m0_ack"}, a0.ack, 0);
    chk({t, "_m1_ack"}, a1.ack, 0);
    chk({t, "_m0_rdata"}, a0.rdata, 0);
    chk({t, "_m1_rdata"}, a1.rdata, 0);
    chk({t, "_mem_addr"}, addr_a, 0);
    chk({t, "_mem_data"}, dout_a, 0);
  endtask

  task automatic tie_run();
    logic [31:0] oa[4], ob[4];
    int na = 0, nb = 0, b_m0_acks = 0, addr_bad = 0;
    for (int i = 0; i < 4; i++) begin oa[i] = 32'hFFFFFFFF; ob[i] = 32'hFFFFFFFF; end
    m0_we = 1; m1_we = 1; m0_addr = 32'h10; m1_addr = 32'h20;
    m0_wdata = 32'hAAAA0000; m1_wdata = 32'hBBBB1111;
    m0_req = 1; m1_req = 1;
    for (int c = 0; c < 60 && (na < 4 || nb < 4); c++) begin
      @(negedge clk);
      if (wr_a && na < 4) begin
        oa[na] = {31'd0, owner_a};
        if (addr_a != (owner_a ? 32'h20 : 32'h10)) addr_bad++;
        na++;
      end
      if (wr_b && nb < 4) begin ob[nb] = {31'd0, owner_b}; nb++; end
      if (b0.ack) b_m0_acks++;
    end
    m0_req = 0; m1_req = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_grant%0d", i), oa[i], {31'd0, i[0]});
      chk($sformatf("fp_grant%0d", i), ob[i], 32'd1);
    end
    chk("rr_addr_matches_owner", addr_bad, 0);
    chk("fp_m0_starved", b_m0_acks, 0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int late_acks;
    vecs[0] = '{0, 0, 32'h00000100, 32'h0,        4, 32'hDEADBEEF, 32'h0,        0};
    vecs[1] = '{1, 1, 32'h00000200, 32'h12345678, 2, 32'hDEADBEEF, 32'h0,        0};
    vecs[2] = '{1, 0, 32'h00000300, 32'h0,        4, 32'hDEADBEEF, 32'h0300FCFF, 0};
    vecs[3] = '{0, 1, 32'h00000104, 32'h000055AA, 2, 32'hDEADBEEF, 32'h0300FCFF, 0};
    vecs[4] = '{0, 0, 32'h000ABCD0, 32'h0,        4, 32'hBCD0432F, 32'h0300FCFF, 0};
    vecs[5] = '{1, 0, 32'h00000044, 32'h0,        4, 32'hBCD0432F, 32'h0044FFBB, 1};
    vecs[6] = '{0, 0, 32'h00000100, 32'h0,        4, 32'hDEADBEEF, 32'h0044FFBB, 0};

    repeat (3) @(negedge clk);
    rst = 0;
    check_reset_outputs("reset");

    for (int i = 0; i < 7; i++) run_txn(vecs[i], i);

    // Abort an M0 read in its first WAIT cycle; last_owner is M0 at this point.
    m0_we = 0; m0_addr = 32'h100; m0_req = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 1; m0_req = 0;
    @(negedge clk);
    rst = 0;
    check_reset_outputs("abort");
    late_acks = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (a0.ack || a1.ack || busy_a) late_acks++;
    end
    chk("abort_no_ack", late_acks, 0);

    m0_we = 1; m1_we = 1; m0_addr = 32'h10; m1_addr = 32'h20; m0_req = 1; m1_req = 1;
    begin
      logic [31:0] first_owner = 32'hFFFFFFFF;
      for (int c = 0; c < 10 && first_owner == 32'hFFFFFFFF; c++) begin
        @(negedge clk);
        if (wr_a) first_owner = {31'd0, owner_a};
      end
      chk("abort_first_tie_owner", first_owner, 0);
    end
    m0_req = 0; m1_req = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;

    tie_run();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
